// File: rtl/gsu_icache_if.sv
// Signal bundle for gsu_icache: GSU fetch port, memory-arbiter read port and SNES host port.
// The cache itself uses the slave modport; the surrounding system (or a bench) uses master.
interface gsu_icache_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic [15:0]       cbr;
  logic              flush;
  logic              fetch_req;
  logic [15:0]       fetch_addr;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_data;
  logic              mem_req;
  logic [15:0]       mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic [DATA_W-1:0] host_dout;

  modport slave (
    input  cbr, flush, fetch_req, fetch_addr, mem_ack, mem_data, host_we, host_addr, host_din,
    output fetch_ack, fetch_data, mem_req, mem_addr, host_dout
  );

  modport master (
    output cbr, flush, fetch_req, fetch_addr, mem_ack, mem_data, host_we, host_addr, host_din,
    input  fetch_ack, fetch_data, mem_req, mem_addr, host_dout
  );
endinterface

// File: rtl/gsu_icache.sv
// GSU instruction cache: CBR-relative window, per-line valid bits, line-fill FSM and write-first host port.
// Optional hit/miss counters are enabled by defining GSU_ICACHE_STATS_EN.
module gsu_icache #(
  parameter int ADDR_W = 9,
  parameter int LINE_W = 4,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  gsu_icache_if.slave bus
`ifdef GSU_ICACHE_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses
`endif
);
  localparam int NBYTES = 2 ** ADDR_W;
  localparam int NLINES = 2 ** (ADDR_W - LINE_W);
  localparam int TAG_W  = ADDR_W - LINE_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, BYPASS} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [NBYTES];
  logic [NLINES-1:0] valid;

  logic [15:0]       req_addr, req_cbr;
  logic [ADDR_W-1:0] req_idx;
  logic              req_in_win;
  logic              fill_flushed;
  logic [LINE_W-1:0] beat;
  logic [DATA_W-1:0] rd_b, resp_data;

  logic              fetch_ack, mem_req;
  logic [DATA_W-1:0] fetch_data, host_dout;
  logic [15:0]       mem_addr;

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_idx;
  logic [DATA_W-1:0] pend_data;

  logic [15:0]       cbr_aligned, win_off;
  logic [TAG_W-1:0]  req_line;
  logic [LINE_W-1:0] req_offs;
  logic              ack_ok;

  logic accept, hit, miss, to_bypass, fill_last, byp_done;
  logic              fill_wr;
  logic [ADDR_W-1:0] fill_idx;
  logic [DATA_W-1:0] fill_data;

  assign cbr_aligned = {bus.cbr[15:LINE_W], {LINE_W{1'b0}}};
  assign win_off     = bus.fetch_addr - cbr_aligned;
  assign req_line    = req_idx[ADDR_W-1:LINE_W];
  assign req_offs    = req_idx[LINE_W-1:0];
  assign ack_ok      = bus.mem_ack && mem_req;

  assign bus.fetch_ack  = fetch_ack;
  assign bus.fetch_data = fetch_data;
  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.host_dout  = host_dout;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_next = state;
    accept     = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    to_bypass  = 1'b0;
    fill_last  = 1'b0;
    byp_done   = 1'b0;
    unique case (state)
      IDLE: begin
        // fetch_ack high means the requester has not yet seen this response and still holds fetch_req.
        if (bus.fetch_req && !fetch_ack && !pend_valid) begin
          accept     = 1'b1;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!req_in_win) begin
          to_bypass  = 1'b1;
          state_next = BYPASS;
        end else if (valid[req_line]) begin
          hit        = 1'b1;
          state_next = IDLE;
        end else begin
          miss       = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (ack_ok && beat == '1) begin
          fill_last  = 1'b1;
          state_next = IDLE;
        end
      end
      BYPASS: begin
        if (ack_ok) begin
          byp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A fill beat that lost port A to the host waits in the pending register.
  always_comb begin
    fill_wr   = 1'b0;
    fill_idx  = {req_line, beat};
    fill_data = bus.mem_data;
    if (pend_valid) begin
      fill_wr   = 1'b1;
      fill_idx  = pend_idx;
      fill_data = pend_data;
    end else if (state == FILL && ack_ok) begin
      fill_wr = 1'b1;
    end
  end

  // NOTE: the byte array carries no reset; its contents survive reset like the original cache RAM.
  always_ff @(posedge clk) begin
    if (bus.host_we)  mem[bus.host_addr] <= bus.host_din;
    else if (fill_wr) mem[fill_idx] <= fill_data;
    if (accept) rd_b <= mem[win_off[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) host_dout <= '0;
    else     host_dout <= bus.host_we ? bus.host_din : mem[bus.host_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_ack    <= 1'b0;
      fetch_data   <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      valid        <= '0;
      req_addr     <= '0;
      req_cbr      <= '0;
      req_idx      <= '0;
      req_in_win   <= 1'b0;
      fill_flushed <= 1'b0;
      beat         <= '0;
      resp_data    <= '0;
      pend_valid   <= 1'b0;
      pend_idx     <= '0;
      pend_data    <= '0;
    end else begin
      state     <= state_next;
      fetch_ack <= hit | fill_last | byp_done;

      if (accept) begin
        req_addr     <= bus.fetch_addr;
        req_cbr      <= cbr_aligned;
        req_idx      <= win_off[ADDR_W-1:0];
        req_in_win   <= (win_off[15:ADDR_W] == '0);
        fill_flushed <= 1'b0;
      end else if (bus.flush) begin
        fill_flushed <= 1'b1;
      end

      if (hit) fetch_data <= rd_b;

      if (miss) begin
        beat     <= '0;
        mem_req  <= 1'b1;
        mem_addr <= req_cbr + 16'({req_line, {LINE_W{1'b0}}});
      end

      if (to_bypass) begin
        mem_req  <= 1'b1;
        mem_addr <= req_addr;
      end

      if (state == FILL) begin
        if (ack_ok) begin
          mem_req <= 1'b0;
          beat    <= beat + LINE_W'(1);
          if (beat == req_offs) resp_data <= bus.mem_data;
          if (fill_last) fetch_data <= (beat == req_offs) ? bus.mem_data : resp_data;
        end else if (!mem_req && !pend_valid) begin
          // Next beat is requested only once the previous beat is safely in the array.
          mem_req  <= 1'b1;
          mem_addr <= req_cbr + 16'({req_line, beat});
        end
      end

      if (byp_done) begin
        mem_req    <= 1'b0;
        fetch_data <= bus.mem_data;
      end

      if (fill_wr && bus.host_we) begin
        pend_valid <= 1'b1;
        pend_idx   <= fill_idx;
        pend_data  <= fill_data;
      end else if (fill_wr) begin
        pend_valid <= 1'b0;
      end

      if (bus.flush) begin
        valid <= '0;
      end else begin
        if (fill_last && !fill_flushed) valid[req_line] <= 1'b1;
        if (bus.host_we && (&bus.host_addr[LINE_W-1:0]))
          valid[bus.host_addr[ADDR_W-1:LINE_W]] <= 1'b1;
      end
    end
  end

`ifdef GSU_ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (hit && stat_hits != 16'hFFFF)    stat_hits   <= stat_hits + 16'd1;
      if (miss && stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gsu_icache.sv
// Directed bench for gsu_icache: fills, hits, bypass, host writes, flush during fill, host/fill port conflict.
module tb_gsu_icache;
  logic clk = 1'b0;
  logic rst;

  gsu_icache_if #(.ADDR_W(9), .DATA_W(8)) bus ();

`ifdef GSU_ICACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  gsu_icache #(.ADDR_W(9), .LINE_W(4), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GSU_ICACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          nreads, lat, bad;
  logic [7:0]  rdata, conf_dout, hdout;
  logic [15:0] addr_log [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one fetch and plays the memory arbiter (data = 8'hA0 + addr[3:0]) until fetch_ack.
  // flush_beat / conf_beat select the read on whose ack a flush or a same-index host write is driven.
  task automatic run_fetch(input logic [15:0] addr, input int flush_beat, input int conf_beat,
                           input logic [7:0] conf_data);
    bit done = 1'b0;
    bit conf_prev = 1'b0;
    @(posedge clk); #1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    nreads = 0;
    lat    = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (conf_prev) conf_dout = bus.host_dout;
      conf_prev   = 1'b0;
      bus.mem_ack = 1'b0;
      bus.flush   = 1'b0;
      bus.host_we = 1'b0;
      if (bus.fetch_ack) begin
        done          = 1'b1;
        rdata         = bus.fetch_data;
        bus.fetch_req = 1'b0;
      end else if (bus.mem_req) begin
        addr_log[nreads[4:0]] = bus.mem_addr;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'hA0 + {4'h0, bus.mem_addr[3:0]};
        if (nreads == flush_beat) bus.flush = 1'b1;
        if (nreads == conf_beat) begin
          bus.host_we   = 1'b1;
          bus.host_addr = bus.mem_addr[8:0];
          bus.host_din  = conf_data;
          conf_prev     = 1'b1;
        end
        nreads++;
      end
    end
    bus.fetch_req = 1'b0;
    check("fetch_ack_seen", 32'(done), 32'd1);
  endtask

  task automatic host_read(input logic [8:0] a);
    bus.host_we   = 1'b0;
    bus.host_addr = a;
    @(posedge clk); #1;
    hdout = bus.host_dout;
  endtask

  initial begin
    rst            = 1'b1;
    bus.cbr        = 16'h8000;
    bus.flush      = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_data   = '0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_din   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fetch_ack", 32'(bus.fetch_ack), 32'd0);
    check("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_host_dout", 32'(bus.host_dout), 32'd0);
    check("rst_valid", 32'(dut.valid), 32'd0);
    rst = 1'b0;

    // Miss on line 0: full 16-beat fill from 8000.
    run_fetch(16'h8005, -1, -1, 8'h00);
    check("fill0_data", 32'(rdata), 32'hA5);
    check("fill0_reads", 32'(nreads), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (addr_log[i] !== 16'h8000 + 16'(i)) bad++;
    check("fill0_addr_errs", 32'(bad), 32'd0);
    check("fill0_valid", 32'(dut.valid), 32'h1);
`ifdef GSU_ICACHE_STATS_EN
    check("stat_misses_1", 32'(stat_misses), 32'd1);
`endif

    // Hit in line 0: two-cycle latency, no memory traffic.
    run_fetch(16'h800A, -1, -1, 8'h00);
    check("hit0_data", 32'(rdata), 32'hAA);
    check("hit0_reads", 32'(nreads), 32'd0);
    check("hit0_latency", 32'(lat), 32'd2);

    // Below the window: single bypass read.
    run_fetch(16'h7FFF, -1, -1, 8'h00);
    check("byp_data", 32'(rdata), 32'hAF);
    check("byp_reads", 32'(nreads), 32'd1);
    check("byp_addr", 32'(addr_log[0]), 32'h7FFF);
    check("byp_valid", 32'(dut.valid), 32'h1);

    // Host fills line 2; last byte marks it valid.
    for (int i = 0; i < 16; i++) begin
      bus.host_we   = 1'b1;
      bus.host_addr = 9'h020 + 9'(i);
      bus.host_din  = 8'h11 + 8'(i);
      @(posedge clk); #1;
      if (i == 0) check("host_write_first", 32'(bus.host_dout), 32'h11);
    end
    bus.host_we = 1'b0;
    check("host_valid", 32'(dut.valid), 32'h5);
    run_fetch(16'h8023, -1, -1, 8'h00);
    check("hit2_data", 32'(rdata), 32'h14);
    check("hit2_reads", 32'(nreads), 32'd0);
    check("hit2_latency", 32'(lat), 32'd2);

    // Flush during the fill: fetch served, line left invalid, so it refills.
    run_fetch(16'h8045, 7, -1, 8'h00);
    check("flush_fill_data", 32'(rdata), 32'hA5);
    check("flush_fill_reads", 32'(nreads), 32'd16);
    check("flush_valid", 32'(dut.valid), 32'h0);
    run_fetch(16'h8045, -1, -1, 8'h00);
    check("refill_reads", 32'(nreads), 32'd16);
    check("refill_data", 32'(rdata), 32'hA5);
    check("refill_valid", 32'(dut.valid), 32'h10);

    // Host write to the index being filled on the same cycle as the fill ack.
    run_fetch(16'h8067, -1, 3, 8'h5C);
    check("conf_data", 32'(rdata), 32'hA7);
    check("conf_reads", 32'(nreads), 32'd16);
    check("conf_host_dout", 32'(conf_dout), 32'h5C);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      host_read(9'h060 + 9'(i));
      if (hdout !== 8'hA0 + 8'(i)) bad++;
    end
    check("conf_line_errs", 32'(bad), 32'd0);
    check("conf_valid", 32'(dut.valid), 32'h50);

    // Low cbr bits are ignored: base stays 8000.
    bus.cbr = 16'h8007;
    run_fetch(16'h800A, -1, -1, 8'h00);
    check("cbr_align_data", 32'(rdata), 32'hAA);
    check("cbr_align_reads", 32'(nreads), 32'd16);
    check("cbr_align_base", 32'(addr_log[0]), 32'h8000);
    check("cbr_align_valid", 32'(dut.valid), 32'h51);
    bus.cbr = 16'h8000;

    // First address past the window bypasses.
    run_fetch(16'h8200, -1, -1, 8'h00);
    check("win_edge_reads", 32'(nreads), 32'd1);
    check("win_edge_addr", 32'(addr_log[0]), 32'h8200);
    check("win_edge_data", 32'(rdata), 32'hA0);

`ifdef GSU_ICACHE_STATS_EN
    check("stat_hits_end", 32'(stat_hits), 32'd2);
    check("stat_misses_end", 32'(stat_misses), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
